// File: rtl/input_vc_buffer.sv
// input_vc_buffer: two-VC input buffer feeding a registered output stage.
// A wormhole lock FSM keeps a packet's flits contiguous on the output, and
// round-robin arbitration chooses between VCs while idle. Each dequeue
// pulses a one-cycle credit back to the upstream router.
// Optional sticky error flags (overflow, protocol) are built only when the
// macro IVB_ERR_CHECK_EN is defined.
module input_vc_buffer #(
  parameter int                FLIT_SIZE   = 64,
  parameter int                DEPTH       = 4,
  parameter int                TYPE_W      = 2,
  parameter logic [TYPE_W-1:0] HEAD_FLIT   = 2'b01,
  parameter logic [TYPE_W-1:0] BODY_FLIT   = 2'b10,
  parameter logic [TYPE_W-1:0] TAIL_FLIT   = 2'b11,
  parameter logic [TYPE_W-1:0] SINGLE_FLIT = 2'b00
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [FLIT_SIZE-1:0] flit_in,
  input  logic                 flit_valid_in,
  input  logic                 vc_in,
  input  logic                 stall,
  output logic [FLIT_SIZE-1:0] flit_out,
  output logic                 flit_valid_out,
  output logic [1:0]           credit_out
`ifdef IVB_ERR_CHECK_EN
  ,
  output logic [1:0]           err
`endif
);
  localparam int               PTR_W    = $clog2(DEPTH);
  localparam int               CNT_W    = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    LOCK0 = 2'b01,
    LOCK1 = 2'b10
  } state_t;

  logic [FLIT_SIZE-1:0] mem_q [2][DEPTH];
  logic [PTR_W-1:0]     rd_ptr_q [2];
  logic [PTR_W-1:0]     rd_ptr_d [2];
  logic [CNT_W-1:0]     count_q [2];
  logic [CNT_W-1:0]     count_d [2];
  state_t               state_q, state_d;
  logic                 last_grant_q, last_grant_d;
  logic [FLIT_SIZE-1:0] flit_out_q;
  logic                 valid_q;
  logic [1:0]           credit_q;

  logic [1:0]           empty_s, full_s, elig_s, deq_vec_s, wr_vec_s;
  logic                 load_s, grant_vld_s, grant_vc_s, deq_s, wr_en_s;
  logic [FLIT_SIZE-1:0] front_s [2];
  logic [FLIT_SIZE-1:0] grant_flit_s;
  logic [TYPE_W-1:0]    grant_type_s;
  logic [PTR_W-1:0]     wr_idx_s;

  // Per-VC occupancy status and the flit at the head of each FIFO
  always_comb begin
    for (int v = 0; v < 2; v++) begin
      empty_s[v] = (count_q[v] == {CNT_W{1'b0}});
      full_s[v]  = (count_q[v] == FULL_CNT);
      front_s[v] = mem_q[v][rd_ptr_q[v]];
    end
  end

  // Lock-aware eligibility, round-robin grant, and write acceptance
  always_comb begin
    elig_s = 2'b00;
    case (state_q)
      IDLE:    elig_s = ~empty_s;
      LOCK0:   elig_s = {1'b0, ~empty_s[0]};
      LOCK1:   elig_s = {~empty_s[1], 1'b0};
      default: elig_s = 2'b00;
    endcase
    load_s      = ~stall | ~valid_q;
    grant_vld_s = |elig_s;
    if (elig_s == 2'b11) begin
      grant_vc_s = ~last_grant_q;
    end else begin
      grant_vc_s = elig_s[1];
    end
    deq_s        = load_s & grant_vld_s;
    deq_vec_s    = {deq_s & grant_vc_s, deq_s & ~grant_vc_s};
    grant_flit_s = front_s[grant_vc_s];
    grant_type_s = grant_flit_s[FLIT_SIZE-1 -: TYPE_W];
    // A read of a full FIFO frees its slot in time for a same-cycle write.
    wr_en_s  = flit_valid_in & (~full_s[vc_in] | deq_vec_s[vc_in]);
    wr_vec_s = {wr_en_s & vc_in, wr_en_s & ~vc_in};
    // Tail slot; when full this equals the slot being read out this cycle.
    wr_idx_s = rd_ptr_q[vc_in] + count_q[vc_in][PTR_W-1:0];
  end

  // FIFO bookkeeping and wormhole lock next-state on each dequeue
  always_comb begin
    for (int v = 0; v < 2; v++) begin
      rd_ptr_d[v] = rd_ptr_q[v] + PTR_W'(deq_vec_s[v]);
      count_d[v]  = count_q[v] + CNT_W'(wr_vec_s[v]) - CNT_W'(deq_vec_s[v]);
    end
    state_d      = state_q;
    last_grant_d = last_grant_q;
    if (deq_s) begin
      last_grant_d = grant_vc_s;
      case (state_q)
        IDLE: begin
          case (grant_type_s)
            HEAD_FLIT:                         state_d = grant_vc_s ? LOCK1 : LOCK0;
            SINGLE_FLIT, BODY_FLIT, TAIL_FLIT: state_d = IDLE;
            default:                           state_d = IDLE;
          endcase
        end
        LOCK0, LOCK1: begin
          if (grant_type_s == TAIL_FLIT) begin
            state_d = IDLE;
          end else begin
            state_d = state_q;
          end
        end
        default: state_d = IDLE;
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // Flit storage; contents need no reset because counts gate visibility
  always_ff @(posedge clk) begin
    if (wr_en_s && !rst) begin
      mem_q[vc_in][wr_idx_s] <= flit_in;
    end
  end

  // Control state, FIFO pointers and the registered output stage
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int v = 0; v < 2; v++) begin
        rd_ptr_q[v] <= {PTR_W{1'b0}};
        count_q[v]  <= {CNT_W{1'b0}};
      end
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      flit_out_q   <= {FLIT_SIZE{1'b0}};
      valid_q      <= 1'b0;
      credit_q     <= 2'b00;
    end else begin
      for (int v = 0; v < 2; v++) begin
        rd_ptr_q[v] <= rd_ptr_d[v];
        count_q[v]  <= count_d[v];
      end
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      credit_q     <= deq_vec_s;
      if (load_s) begin
        valid_q <= grant_vld_s;
        if (grant_vld_s) begin
          flit_out_q <= grant_flit_s;
        end
      end
    end
  end

  assign flit_out       = flit_out_q;
  assign flit_valid_out = valid_q;
  assign credit_out     = credit_q;

`ifdef IVB_ERR_CHECK_EN
  logic [1:0] err_q;
  logic       proto_bad_s;

  // Front flit type that contradicts the current lock state
  always_comb begin
    proto_bad_s = 1'b0;
    case (state_q)
      IDLE:         proto_bad_s = (grant_type_s == BODY_FLIT) || (grant_type_s == TAIL_FLIT);
      LOCK0, LOCK1: proto_bad_s = (grant_type_s == HEAD_FLIT) || (grant_type_s == SINGLE_FLIT);
      default:      proto_bad_s = 1'b0;
    endcase
  end

  // Sticky overflow / protocol flags, cleared only by reset
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 2'b00;
    end else begin
      if (flit_valid_in && !wr_en_s) begin
        err_q[0] <= 1'b1;
      end
      if (deq_s && proto_bad_s) begin
        err_q[1] <= 1'b1;
      end
    end
  end

  assign err = err_q;
`endif

endmodule

// File: tb/tb_input_vc_buffer.sv
// Bench for input_vc_buffer: directed scenarios plus randomized packet
// traffic, checked against a queue-based reference model and scoreboard.
module tb_input_vc_buffer;
  localparam int         FW     = 64;
  localparam int         DEPTH  = 4;
  localparam logic [1:0] SINGLE = 2'b00;
  localparam logic [1:0] HEAD   = 2'b01;
  localparam logic [1:0] BODY   = 2'b10;
  localparam logic [1:0] TAIL   = 2'b11;

  logic          clk = 1'b0;
  logic          rst, flit_valid_in, vc_in, stall;
  logic [FW-1:0] flit_in, flit_out;
  logic          flit_valid_out;
  logic [1:0]    credit_out;
`ifdef IVB_ERR_CHECK_EN
  logic [1:0]    err;
`endif

  input_vc_buffer #(.FLIT_SIZE(FW), .DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst            (rst),
    .flit_in        (flit_in),
    .flit_valid_in  (flit_valid_in),
    .vc_in          (vc_in),
    .stall          (stall),
    .flit_out       (flit_out),
    .flit_valid_out (flit_valid_out),
    .credit_out     (credit_out)
`ifdef IVB_ERR_CHECK_EN
    ,
    .err            (err)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int seq      = 0;
  int rem0     = 0;
  int rem1     = 0;

  // Reference model state: per-VC flit queues, lock owner (-1 = none)
  logic [FW-1:0] mq0[$];
  logic [FW-1:0] mq1[$];
  int            m_lock  = -1;
  int            m_last  = 1;
  logic          m_valid = 1'b0;
  logic [FW-1:0] m_out   = '0;
  logic [1:0]    m_credit = 2'b00;
`ifdef IVB_ERR_CHECK_EN
  logic [1:0]    m_err   = 2'b00;
`endif

  typedef struct packed {
    logic          vc;
    logic [FW-1:0] f;
  } exp_t;
  exp_t exp_q[$];

  task automatic chk(input string nm, input logic [FW-1:0] act, input logic [FW-1:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, req, $time);
  endtask

  // Reference model: evaluates the buffer rules at each rising edge
  initial begin : model
    logic          e0, e1, load;
    int            g;
    logic [FW-1:0] f;
    logic [1:0]    ty;
    forever begin
      @(posedge clk);
      if (rst) begin
        mq0.delete(); mq1.delete(); exp_q.delete();
        m_lock = -1; m_last = 1; m_valid = 1'b0; m_out = '0; m_credit = 2'b00;
`ifdef IVB_ERR_CHECK_EN
        m_err = 2'b00;
`endif
      end else begin
        load = !stall || !m_valid;
        e0 = (m_lock != 1) && (mq0.size() > 0);
        e1 = (m_lock != 0) && (mq1.size() > 0);
        if (e0 && e1) g = 1 - m_last;
        else if (e0)  g = 0;
        else if (e1)  g = 1;
        else          g = -1;
        m_credit = 2'b00;
        if (load) begin
          if (g >= 0) begin
            f = (g == 1) ? mq1.pop_front() : mq0.pop_front();
            ty = f[FW-1 -: 2];
            m_out = f; m_valid = 1'b1; m_last = g;
            m_credit = (g == 1) ? 2'b10 : 2'b01;
            exp_q.push_back('{vc: (g == 1), f: f});
`ifdef IVB_ERR_CHECK_EN
            if (m_lock == -1 && (ty == BODY || ty == TAIL)) m_err[1] = 1'b1;
            if (m_lock != -1 && (ty == HEAD || ty == SINGLE)) m_err[1] = 1'b1;
`endif
            if (m_lock == -1 && ty == HEAD) m_lock = g;
            else if (m_lock == g && ty == TAIL) m_lock = -1;
          end else begin
            m_valid = 1'b0;
          end
        end
        // Writes land after the read, so a full FIFO being read accepts one.
        if (flit_valid_in) begin
          if (vc_in && mq1.size() < DEPTH) mq1.push_back(flit_in);
          else if (!vc_in && mq0.size() < DEPTH) mq0.push_back(flit_in);
`ifdef IVB_ERR_CHECK_EN
          else m_err[0] = 1'b1;
`endif
        end
      end
    end
  end

  // Monitor: compares outputs on the falling edge and drains the scoreboard
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      chk("valid", FW'(flit_valid_out), FW'(m_valid));
      chk("credit", FW'(credit_out), FW'(m_credit));
      chk("flit_out", flit_out, m_out);
`ifdef IVB_ERR_CHECK_EN
      chk("err", FW'(err), FW'(m_err));
`endif
      if (credit_out != 2'b00) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL sb_underflow: dequeue credit %b with no expected flit", credit_out);
        end else begin
          e = exp_q.pop_front();
          chk("sb_flit", flit_out, e.f);
          chk("sb_vc", FW'(credit_out), FW'(e.vc ? 2'b10 : 2'b01));
        end
      end
    end
  end

  task automatic cyc(input logic v, input logic vc, input logic [1:0] ty, input logic st);
    flit_valid_in = v;
    vc_in         = vc;
    stall         = st;
    flit_in       = {ty, vc, seq[28:0], 32'($urandom)};
    seq++;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, SINGLE, 1'b0);
  endtask

  function automatic logic [1:0] next_type(inout int rem);
    int len;
    if (rem == 0) begin
      len = int'($urandom_range(4, 1));
      if (len == 1) return SINGLE;
      rem = len - 1;
      return HEAD;
    end
    rem--;
    return (rem == 0) ? TAIL : BODY;
  endfunction

  task automatic rand_cyc();
    logic       v, vc;
    logic [1:0] ty;
    int         sz;
    vc = 1'($urandom_range(1));
    sz = vc ? mq1.size() : mq0.size();
    v  = ($urandom_range(99) < 60) && (sz < DEPTH);
    ty = BODY;
    if (v) begin
      if (vc) ty = next_type(rem1);
      else    ty = next_type(rem0);
    end
    cyc(v, vc, ty, $urandom_range(99) < 30);
  endtask

  initial begin : stim
    rst = 1'b1; flit_valid_in = 1'b0; vc_in = 1'b0; stall = 1'b0; flit_in = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Single flit on VC0: visible one cycle after it is written
    cyc(1'b1, 1'b0, SINGLE, 1'b0);
    idle(3);

    // Interleaved 3-flit packets on VC1 and VC0
    cyc(1'b1, 1'b1, HEAD, 1'b0); cyc(1'b1, 1'b0, HEAD, 1'b0);
    cyc(1'b1, 1'b1, BODY, 1'b0); cyc(1'b1, 1'b0, BODY, 1'b0);
    cyc(1'b1, 1'b1, TAIL, 1'b0); cyc(1'b1, 1'b0, TAIL, 1'b0);
    idle(8);

    // Stall with a valid output while VC0 fills and then overflows
    cyc(1'b1, 1'b0, SINGLE, 1'b0);
    for (int i = 0; i < 6; i++) cyc(1'b1, 1'b0, SINGLE, 1'b1);
    // Full VC0 read and written in the same cycles
    for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, SINGLE, 1'b0);
    idle(8);

    // Reset in the middle of a locked VC0 packet
    cyc(1'b1, 1'b0, HEAD, 1'b0);
    cyc(1'b1, 1'b0, BODY, 1'b0);
    cyc(1'b1, 1'b0, BODY, 1'b0);
    rst = 1'b1;
    cyc(1'b1, 1'b0, BODY, 1'b0);
    rst = 1'b0;
    cyc(1'b1, 1'b1, HEAD, 1'b0);
    cyc(1'b1, 1'b1, TAIL, 1'b0);
    idle(4);

    // Body flit reaching an idle VC0 (protocol violation)
    cyc(1'b1, 1'b0, BODY, 1'b0);
    idle(3);
    rst = 1'b1;
    idle(2);
    rst = 1'b0;

    // Randomized legal packet traffic with random stalls
    for (int i = 0; i < 3000; i++) rand_cyc();
    idle(30);

    chk("sb_empty", FW'(exp_q.size()), FW'(0));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/input_vc_buffer.md
INPUT_VC_BUFFER -- requirements
Module: input_vc_buffer

Interface
REQ-001 SHALL have parameter FLIT_SIZE, default 64, flit width in bits.
REQ-002 SHALL have parameter DEPTH, default 4, entries per VC FIFO, power of two, at least 2.
REQ-003 SHALL have parameter TYPE_W, default 2: flit type field is flit[FLIT_SIZE-1 : FLIT_SIZE-TYPE_W].
REQ-004 SHALL have parameters HEAD_FLIT 2'b01, BODY_FLIT 2'b10, TAIL_FLIT 2'b11, SINGLE_FLIT 2'b00 as the type encodings.
REQ-005 SHALL have port clk, input, 1 bit: clock.
REQ-006 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-007 SHALL have port flit_in, input, FLIT_SIZE bits: flit arriving from the upstream link.
REQ-008 SHALL have port flit_valid_in, input, 1 bit: flit_in is valid this cycle.
REQ-009 SHALL have port vc_in, input, 1 bit: VC class (0/1) into which flit_in is written.
REQ-010 SHALL have port stall, input, 1 bit: downstream route-computation stage cannot accept a flit.
REQ-011 SHALL have port flit_out, output, FLIT_SIZE bits: registered flit to route computation.
REQ-012 SHALL have port flit_valid_out, output, 1 bit: flit_out is valid.
REQ-013 SHALL have port credit_out, output, 2 bits: one-cycle pulse per VC on dequeue; credit return to upstream.
REQ-014 SHALL have port err, output, 2 bits: sticky error flags, present only with IVB_ERR_CHECK_EN (bit0 overflow, bit1 protocol).

Function
REQ-015 SHALL hold two independent circular FIFOs, one per VC, each DEPTH entries, with ptr+count state (count width log2(DEPTH)+1).
REQ-016 SHALL write flit_in to FIFO[vc_in] at the clock edge where flit_valid_in=1 and that FIFO is not full; a write to a full FIFO is dropped.
REQ-017 SHALL compute load = ~stall | ~flit_valid_out; only when load=1 may the output register take a new flit.
REQ-018 SHALL, when load=1 and a VC is granted, move that VC's front flit into flit_out, set flit_valid_out=1, and pulse credit_out[vc]=1 for exactly that cycle.
REQ-019 SHALL, when load=1 and no VC is eligible, clear flit_valid_out to 0; flit_out keeps its old value.
REQ-020 SHALL, when stall=1 and flit_valid_out=1, hold flit_out, flit_valid_out and all FIFO read pointers unchanged.
REQ-021 SHALL have minimum latency 1 cycle: a flit written at edge N, into an empty FIFO with load=1 at edge N+1, appears on flit_out after edge N+1.
REQ-022 SHALL allow simultaneous write and read of the same FIFO in one cycle, including when full (a read frees the entry first, so the write is accepted) and when empty (the write is not visible to the read until the next cycle).
REQ-023 SHALL implement a wormhole lock FSM with states IDLE, LOCK0, LOCK1.
REQ-024 SHALL, in IDLE, treat a VC as eligible when it is non-empty; with both VCs eligible it grants the VC other than last_grant (round-robin); last_grant resets to 1.
REQ-025 SHALL, in IDLE, move to LOCKx on dequeuing a HEAD_FLIT from VC x, and stay in IDLE on dequeuing a SINGLE_FLIT.
REQ-026 SHALL, in LOCKx, make only VC x eligible, and return to IDLE on dequeuing a TAIL_FLIT from VC x; an empty VC x stalls output (bubble) without unlocking.
REQ-027 SHALL update last_grant to x on every dequeue from VC x.
REQ-028 SHALL pass flits through bit-exact; the block does not modify the type, VC class or dst fields.

Reset
REQ-029 SHALL, with rst=1 at a clock edge, set both FIFO counts/pointers to 0, FSM to IDLE, flit_valid_out=0, credit_out=0, err=0, and flit_out=0.
REQ-030 SHALL discard all buffered flits and any partially forwarded packet on reset mid-operation, and ignore writes in that cycle.

Configuration
REQ-031 SHALL, with IVB_ERR_CHECK_EN defined, set err[0] on a write to a full FIFO and set err[1] when, in IDLE, the granted front flit is BODY or TAIL, or, in LOCKx, the front flit is HEAD or SINGLE; flags clear only on reset.
REQ-032 SHALL, with IVB_ERR_CHECK_EN undefined, omit the err port and its logic, with all other behaviour identical.

Verification
REQ-033 SHALL cover: single SINGLE_FLIT on VC0 at cycle 0, stall=0 -> flit_out valid at cycle 1, credit_out=2'b01 at cycle 1.
REQ-034 SHALL cover: 3-flit packet on VC1 (HEAD, BODY, TAIL) interleaved per cycle with a 3-flit packet on VC0 -> output shows all three flits of the first granted VC contiguously, then the other VC's three.
REQ-035 SHALL cover: stall held 5 cycles with flit_valid_out=1 -> flit_out constant, credit_out=0, FIFO fills to DEPTH=4, 5th write sets err[0] (macro on).
REQ-036 SHALL cover: full VC0 with simultaneous read and write -> write accepted, count stays 4, order preserved.
REQ-037 SHALL cover: rst asserted mid-packet in LOCK0 -> next cycle flit_valid_out=0, FSM IDLE, a new HEAD on VC1 is forwarded.
REQ-038 SHALL cover: BODY_FLIT written to an idle VC0 -> err=2'b10 with the macro defined; no err port with the macro undefined.
